// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// uart_core_param : parametrised full-duplex UART, 16x oversampled receiver
// Revision 1.0
// ============================================================================
module uart_core_param #(
  parameter int BAUD_DIV  = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int c_bit_clks = 16 * BAUD_DIV;
  localparam int c_tw       = $clog2(c_bit_clks);
  localparam int c_dw       = $clog2(BAUD_DIV);
  localparam logic [c_tw-1:0] c_timer_last = c_tw'(c_bit_clks - 1);
  localparam logic [c_dw-1:0] c_div_last   = c_dw'(BAUD_DIV - 1);
  localparam logic [3:0]      c_data_last  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_stop_last  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- transmitter ----------------
  state_e                tx_state_q, tx_state_d;
  logic [c_tw-1:0]       tx_timer_q, tx_timer_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_out_q, tx_out_d;
  logic                  w_tx_bit_end;

  assign w_tx_bit_end = (tx_timer_q == c_timer_last);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = w_tx_bit_end ? '0 : tx_timer_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_timer_d = '0;
        tx_out_d   = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = calc_par(tx_data);
          tx_out_d   = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: if (w_tx_bit_end) begin
        tx_out_d   = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (w_tx_bit_end) begin
        if (tx_bit_q == c_data_last) begin
          tx_bit_d = '0;
          if (PARITY != 0) begin
            tx_out_d   = tx_par_q;
            tx_state_d = S_PARITY;
          end else begin
            tx_out_d   = 1'b1;
            tx_state_d = S_STOP;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
        end
      end
      S_PARITY: if (w_tx_bit_end) begin
        tx_out_d   = 1'b1;
        tx_state_d = S_STOP;
      end
      S_STOP: if (w_tx_bit_end) begin
        if (tx_bit_q == c_stop_last) tx_state_d = S_IDLE;
        else                         tx_bit_d   = tx_bit_q + 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign tx_ready = (tx_state_q == S_IDLE);
  assign tx_out   = tx_out_q;

  // ---------------- receiver ----------------
  logic [1:0]            sync_q;
  logic [c_dw-1:0]       div_q;
  logic                  w_line, w_tick;
  state_e                rx_state_q, rx_state_d;
  logic [3:0]            rx_tick_q, rx_tick_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_par_bit_q, rx_par_bit_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;

  assign w_line = sync_q[1];
  assign w_tick = (div_q == c_div_last);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (w_tick) begin
      rx_tick_d = rx_tick_q + 1'b1;
      case (rx_state_q)
        S_IDLE: begin
          rx_tick_d = '0;
          if (!w_line) rx_state_d = S_START;
        end
        // mid-start check rejects glitches shorter than half a bit
        S_START: if (rx_tick_q == 4'd7) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = w_line ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_tick_q == 4'd15) begin
          rx_shift_d = {w_line, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == c_data_last)
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else
            rx_bit_d = rx_bit_q + 1'b1;
        end
        S_PARITY: if (rx_tick_q == 4'd15) begin
          rx_par_bit_d = w_line;
          rx_state_d   = S_STOP;
        end
        S_STOP: if (rx_tick_q == 4'd15) begin
          rx_valid_d   = 1'b1;
          rx_data_d    = rx_shift_q;
          parity_err_d = (PARITY != 0) && (rx_par_bit_q != calc_par(rx_shift_q));
          frame_err_d  = ~w_line;
          rx_state_d   = S_IDLE;
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      div_q        <= '0;
      rx_state_q   <= S_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bit_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], (loopback ? tx_out_q : rx_in)};
      div_q        <= w_tick ? '0 : div_q + 1'b1;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bit_q <= rx_par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
// tb_uart_core_param : three UART configurations (8N1, 8E1, 8N2) against a
// bit-index frame model and an expected-receive queue. Revision 1.0
// ============================================================================
module tb_uart_core_param;
  localparam int c_bit = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tx_valid_v [3];
  logic [7:0] tx_data_v  [3];
  logic       rx_in_v    [3];
  logic       loopback_v [3];
  logic       tx_ready_v [3];
  logic       tx_out_v   [3];
  logic       rx_valid_v [3];
  logic       perr_v     [3];
  logic       ferr_v     [3];
  logic [7:0] rx_data_v  [3];

  uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_v[0]), .tx_out(tx_out_v[0]), .rx_in(rx_in_v[0]),
    .loopback(loopback_v[0]), .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]),
    .parity_err(perr_v[0]), .frame_err(ferr_v[0]));
  uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_v[1]), .tx_out(tx_out_v[1]), .rx_in(rx_in_v[1]),
    .loopback(loopback_v[1]), .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]),
    .parity_err(perr_v[1]), .frame_err(ferr_v[1]));
  uart_core_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_8n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_v[2]), .tx_out(tx_out_v[2]), .rx_in(rx_in_v[2]),
    .loopback(loopback_v[2]), .rx_data(rx_data_v[2]), .rx_valid(rx_valid_v[2]),
    .parity_err(perr_v[2]), .frame_err(ferr_v[2]));

  function automatic int par_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction
  function automatic int stop_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int nbits(input int i);
    return 9 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i);
  endfunction
  // Line level of bit b of a frame carrying d, for configuration i
  function automatic logic frame_bit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_of(i) != 0 && b == 9) return (par_of(i) == 1) ? ~^d : ^d;
    return 1'b1;
  endfunction

  // Transmit model: frame position counted in clocks since accept
  logic       m_active [3];
  int         m_j      [3];
  logic [7:0] m_data   [3];
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_active[i] <= 1'b0;
        m_j[i]      <= 0;
      end else if (m_active[i]) begin
        m_j[i] <= m_j[i] + 1;
        if (m_j[i] + 1 == nbits(i) * c_bit) m_active[i] <= 1'b0;
      end else if (tx_valid_v[i]) begin
        m_active[i] <= 1'b1;
        m_j[i]      <= 0;
        m_data[i]   <= tx_data_v[i];
      end
    end
  end

  function automatic logic exp_tx(input int i);
    return m_active[i] ? frame_bit(i, m_data[i], m_j[i] / c_bit) : 1'b1;
  endfunction

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [11:0] exp_q [$];   // {instance, data, parity_err, frame_err}

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [11:0] e;
    for (int i = 0; i < 3; i++) begin
      check("tx_out", i, 32'(tx_out_v[i]), 32'(exp_tx(i)));
      check("tx_ready", i, 32'(tx_ready_v[i]), 32'(!m_active[i]));
      if (rx_valid_v[i]) begin
        check("rx_pending", i, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rx_inst", i, 32'(e[11:10]), 32'(i));
          check("rx_data", i, 32'(rx_data_v[i]), 32'(e[9:2]));
          check("parity_err", i, 32'(perr_v[i]), 32'(e[1]));
          check("frame_err", i, 32'(ferr_v[i]), 32'(e[0]));
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic expect_rx(input int i, input logic [7:0] d, input logic p, input logic f);
    exp_q.push_back({2'(i), d, p, f});
  endtask

  task automatic wait_rx(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("rx_drain", 0, 32'(exp_q.size()), 32'd0);
  endtask

  // Accept one byte, then watch the whole frame: mid-bit levels and busy time
  task automatic run_tx(input int i, input logic [7:0] d, output logic [15:0] lv,
                        output int low);
    tx_data_v[i]  = d;
    tx_valid_v[i] = 1'b1;
    step();
    tx_valid_v[i] = 1'b0;
    lv  = '0;
    low = 0;
    for (int j = 0; j < nbits(i) * c_bit + 8; j++) begin
      if (j % c_bit == c_bit / 2) lv[j / c_bit] = tx_out_v[i];
      if (!tx_ready_v[i]) low++;
      step();
    end
  endtask

  task automatic drive_rx(input int i, input logic [15:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      rx_in_v[i] = bits[b];
      repeat (c_bit) step();
    end
    rx_in_v[i] = 1'b1;
  endtask

  initial begin
    logic [15:0] lv;
    int          low, f1, f2, rdy_hi, pulses;
    logic        prev;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_valid_v[i] = 1'b0;
      tx_data_v[i]  = 8'h00;
      rx_in_v[i]    = 1'b1;
      loopback_v[i] = 1'b1;
    end
    repeat (4) step();
    check("rst_tx_out", 0, 32'(tx_out_v[0]), 32'd1);
    check("rst_tx_ready", 0, 32'(tx_ready_v[0]), 32'd1);
    check("rst_rx_data", 0, 32'(rx_data_v[0]), 32'd0);
    check("rst_rx_valid", 0, 32'(rx_valid_v[0]), 32'd0);
    check("rst_flags", 0, 32'({perr_v[0], ferr_v[0]}), 32'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // 8N1 loopback of 0xA5
    expect_rx(0, 8'hA5, 1'b0, 1'b0);
    run_tx(0, 8'hA5, lv, low);
    check("t1_levels", 0, 32'(lv[9:0]), 32'h34A);
    check("t1_busy_clks", 0, 32'(low), 32'd640);
    wait_rx(200);

    // 8E1: parity bit on the line, then an externally injected bad parity
    expect_rx(1, 8'hD5, 1'b0, 1'b0);
    run_tx(1, 8'hD5, lv, low);
    check("t2_parity_bit", 1, 32'(lv[9]), 32'd1);
    check("t2_busy_clks", 1, 32'(low), 32'd704);
    wait_rx(200);
    loopback_v[1] = 1'b0;
    repeat (16) step();
    expect_rx(1, 8'hD5, 1'b1, 1'b0);
    drive_rx(1, {5'b0, 1'b1, 1'b0, 8'hD5, 1'b0}, 11);
    wait_rx(200);
    check("t2_perr_hold", 1, 32'(perr_v[1]), 32'd1);

    // Framing error, then a clean frame clears it
    loopback_v[0] = 1'b0;
    repeat (16) step();
    expect_rx(0, 8'h3C, 1'b0, 1'b1);
    drive_rx(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    repeat (128) step();
    wait_rx(200);
    check("t3_ferr_hold", 0, 32'(ferr_v[0]), 32'd1);
    expect_rx(0, 8'h11, 1'b0, 1'b0);
    drive_rx(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    wait_rx(200);
    check("t3_ferr_clear", 0, 32'(ferr_v[0]), 32'd0);

    // 12-clock low glitch must be rejected
    pulses = 0;
    rx_in_v[0] = 1'b0;
    repeat (12) begin step(); pulses += int'(rx_valid_v[0]); end
    rx_in_v[0] = 1'b1;
    repeat (150) begin step(); pulses += int'(rx_valid_v[0]); end
    check("t4_glitch_pulses", 0, 32'(pulses), 32'd0);
    expect_rx(0, 8'h7E, 1'b0, 1'b0);
    drive_rx(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10);
    wait_rx(200);

    // 8N2 back-to-back with tx_valid held high
    expect_rx(2, 8'h00, 1'b0, 1'b0);
    expect_rx(2, 8'hFF, 1'b0, 1'b0);
    tx_data_v[2]  = 8'h00;
    tx_valid_v[2] = 1'b1;
    f1 = -1; f2 = -1; rdy_hi = 0;
    prev = tx_out_v[2];
    for (int n = 0; n < 2000 && f2 < 0; n++) begin
      step();
      if (prev && !tx_out_v[2]) begin
        if (f1 < 0) begin
          f1 = cyc;
          tx_data_v[2] = 8'hFF;
        end else begin
          f2 = cyc;
          tx_valid_v[2] = 1'b0;
        end
      end else if (f1 >= 0 && tx_ready_v[2]) begin
        rdy_hi++;
      end
      prev = tx_out_v[2];
    end
    tx_valid_v[2] = 1'b0;
    check("t5_start_spacing", 2, 32'(f2 - f1), 32'd705);
    check("t5_ready_gap", 2, 32'(rdy_hi), 32'd1);
    wait_rx(1000);
    repeat (100) step();

    // Reset in the middle of a loopback frame
    loopback_v[0] = 1'b1;
    repeat (16) step();
    tx_data_v[0]  = 8'hC3;
    tx_valid_v[0] = 1'b1;
    step();
    tx_valid_v[0] = 1'b0;
    repeat (200) step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_out", 0, 32'(tx_out_v[0]), 32'd1);
    check("t6_rst_tx_ready", 0, 32'(tx_ready_v[0]), 32'd1);
    check("t6_rst_rx_valid", 0, 32'(rx_valid_v[0]), 32'd0);
    repeat (5) step();
    rst_n = 1'b1;
    repeat (100) step();
    expect_rx(0, 8'h5A, 1'b0, 1'b0);
    run_tx(0, 8'h5A, lv, low);
    check("t6_levels", 0, 32'(lv[9:0]), 32'h2B4);
    wait_rx(200);
    check("t6_rx_data", 0, 32'(rx_data_v[0]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised, single-clock full-duplex UART core; successor to the fixed 8-bit transmitter/receiver/baud-generator trio.
- Generalises data width, parity mode, stop-bit count and baud divisor.
- Adds a 16x-oversampling receiver with false-start rejection, parity/framing error flags, a valid/ready transmit handshake and a runtime loopback mux.
- Sits between a byte-level client and the serial pins.

Parameters:
- BAUD_DIV, 4, clk cycles per oversample tick; one bit time = 16*BAUD_DIV clocks (legal >= 2).
- DATA_BITS, 8, payload bits per frame (legal 5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  DATA_BITS  byte to send; sampled only at accept
- tx_valid  input  1  client requests transmission
- tx_ready  output  1  high while the transmitter is idle
- tx_out  output  1  serial line out; idle high
- rx_in  input  1  serial line in; asynchronous
- loopback  input  1  1 = receiver takes tx_out instead of rx_in
- rx_data  output  DATA_BITS  last received payload
- rx_valid  output  1  one-clk pulse per received frame
- parity_err  output  1  parity mismatch on last frame (0 when PARITY=0)
- frame_err  output  1  first stop bit sampled low on last frame

Behaviour:
- Reset: one clock and one reset (clk, async active-low rst_n); all state clears immediately on rst_n low. Reset values: tx_out=1, tx_ready=1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0; both FSMs return to IDLE. Reset mid-frame aborts the frame; no partial rx_valid.
- Tick generator: free-running counter 0..BAUD_DIV-1; one-clk tick at terminal count. Drives the receiver only.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - tx_ready = (state==IDLE). Accept = tx_valid && tx_ready at a clk edge.
  - At accept: latch tx_data; clear a private bit timer; enter START.
  - tx_out=0 from the cycle after accept. Each bit is held exactly 16*BAUD_DIV clocks.
  - DATA sends LSB first, DATA_BITS bits. PARITY state is skipped when PARITY=0; odd parity = ~^data, even = ^data. STOP holds 1 for STOP_BITS bit times, then IDLE.
  - Frame length N = 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits. With tx_valid held high, consecutive start bits are N*16*BAUD_DIV+1 clocks apart.
  - tx_valid while busy is ignored; tx_data changes while busy have no effect.
- RX path:
  - Line = loopback ? tx_out : rx_in, passed through a 2-flop synchroniser (set to 1 on reset).
  - All RX decisions occur on ticks.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE: on a tick with line=0, enter START and clear the tick count.
  - START: after 8 ticks, sample the line. If it is 1 (false start), return to IDLE with no output change. If 0, enter DATA.
  - DATA/PARITY/STOP: sample every 16 ticks (mid-bit). Shift data LSB first; compute expected parity as in TX.
  - STOP: sample the first stop bit, then pulse rx_valid for one clk. In that same cycle update rx_data, parity_err (sampled parity != expected) and frame_err (stop==0), then return to IDLE.
  - Flags and rx_data hold until the next rx_valid.
  - A frame with errors still produces rx_valid and rx_data. After a frame_err with the line held low, the receiver re-arms in IDLE and treats the low level as a new start.
- Simultaneous events: TX and RX are independent; accept and rx_valid may coincide.
- Toggling loopback mid-frame may corrupt that RX frame (flags set) but never hangs either FSM. Change loopback only while both are idle.

Test Plan:
1. Defaults (8N1, BAUD_DIV=4, loopback=1), send 0xA5 -> tx_out levels 0,1,0,1,0,0,1,0,1,1, each 64 clk; one rx_valid with rx_data=0xA5, both flags 0; tx_ready low for exactly 640 clk.
2. PARITY=2, send 0xD5 -> parity bit 1 on tx_out, rx parity_err=0. Then drive rx_in externally with the same frame and parity bit 0 -> rx_valid, rx_data=0xD5, parity_err=1.
3. loopback=0, rx_in frame 0x3C with stop bit driven low -> rx_valid pulses, rx_data=0x3C, frame_err=1. Next clean frame 0x11 -> frame_err=0.
4. rx_in low glitch of 12 clk (3 ticks) -> no rx_valid, FSM back in IDLE. A following frame 0x7E is received correctly.
5. STOP_BITS=2, tx_valid held high with 0x00 then 0xFF -> start bits 11*64+1 clk apart; tx_ready high exactly one cycle between frames; RX yields 0x00 then 0xFF.
6. rst_n asserted 200 clk into a TX and RX frame -> tx_out=1 and tx_ready=1 immediately; no rx_valid. A full frame 0x5A after release is sent and received correctly.
